cu_dcdr_pipe: RTL and testbench
===============================

CU_DCDR_PIPE -- requirements
Module: cu_dcdr_pipe

Interface
REQ-001 Parameter XLEN, default 32, is the datapath and immediate width and SHALL be at least 32.
REQ-002 Parameter EN_MEXT, default 0; when 1, the block SHALL decode RV32M (func7=0000001, opcode 0110011).
REQ-003 Parameter CNT_W, default 16, is the stall-counter width.
REQ-004 Ports SHALL be exactly the following (name, direction, width, meaning), one per line.
CLK  in  1  rising-edge clock; sole clock.
RST  in  1  synchronous, active-high reset.
in_valid  in  1  ir/pc_in hold an instruction.
in_ready  out  1  block accepts the instruction this cycle.
ir  in  32  fetched instruction.
pc_in  in  XLEN  PC of ir.
flush  in  1  discard the staged and incoming instruction.
out_valid  out  1  decoded control word is valid.
out_ready  in  1  execute stage takes the control word.
alu_fun  out  4  ALU operation.
alu_srcA  out  1  ALU A select.
alu_srcB  out  2  ALU B select.
rf_wr_sel  out  2  register-write source: 0=PC+4, 2=memory, 3=ALU.
rf_we, mem_we, mem_rd  out  1 each  register write, store, load.
is_branch, is_jal, is_jalr  out  1 each  control-flow class.
br_fun  out  3  branch func3, resolved in execute.
mext  out  1  M-extension operation; mext_fun out 3 = its func3.
rs1, rs2, rd  out  5 each  register addresses.
imm  out  XLEN  sign-extended immediate for the instruction format.
pc_out  out  XLEN  PC of the staged instruction.
illegal  out  1  staged instruction is not decodable.
stall_cnt  out  CNT_W  count of load-use stall cycles.

Function
REQ-005 The output stage SHALL be one register; adv = out_ready | ~out_valid.
REQ-006 in_ready SHALL equal adv & ~hz & ~flush, combinationally.
REQ-007 hz SHALL be 1 when all hold: out_valid=1, mem_rd=1, rd!=0, and ir uses rs1 (every opcode except LUI, AUIPC, JAL) or rs2 (R, store, branch) with that index equal to rd.
REQ-008 On adv with in_valid & in_ready, all outputs SHALL load the decode of ir and pc_in, and out_valid SHALL go to 1.
REQ-009 On adv without acceptance, out_valid SHALL go to 0, and rf_we, mem_we, mem_rd, is_* and mext SHALL go to 0 (bubble).
REQ-010 When flush=1, out_valid SHALL be 0 the next cycle, regardless of out_ready.
REQ-011 When adv=0 and flush=0, all outputs SHALL hold.
REQ-012 Decode for R-type: alu_fun={f7[5],f3}, srcA=0, srcB=00, rf_wr_sel=3, rf_we=1.
REQ-013 Decode for I-ALU: srcB=01, rf_wr_sel=3, rf_we=1; alu_fun={f7[5],f3} for f3=101, else {0,f3}.
REQ-014 Decode for load: alu_fun=0000, srcB=01, rf_wr_sel=2, rf_we=1, mem_rd=1.
REQ-015 Decode for store: alu_fun=0000, srcB=10, mem_we=1.
REQ-016 Decode for branch: is_branch=1, br_fun=f3.
REQ-017 Decode for LUI: alu_fun=1001, srcA=1, rf_wr_sel=3.
REQ-018 Decode for AUIPC: alu_fun=0000, srcA=1, srcB=11, rf_wr_sel=3.
REQ-019 Decode for JAL: is_jal=1, rf_wr_sel=0. Decode for JALR: is_jalr=1, rf_wr_sel=0. rf_we=1 for LUI, AUIPC, JAL and JALR.
REQ-020 rf_we SHALL be forced to 0 when rd=0.
REQ-021 The following SHALL set illegal=1 and clear every write/enable output, while out_valid is still set: an unknown opcode; branch f3 of 010 or 011; R-type func7 not in {0000000, 0100000, and 0000001 when EN_MEXT=1}; a shift-immediate with func7 not in {0000000, 0100000}.
REQ-022 For M instructions with EN_MEXT=1: mext=1, mext_fun=f3, rf_we=1, rf_wr_sel=3, alu_fun=0000.
REQ-023 imm SHALL be sign-extended from ir[31] to XLEN; U-type imm = {ir[31:12],12'b0}, sign-extended.
REQ-024 stall_cnt SHALL increment by 1 on each cycle with in_valid & hz & adv, and SHALL saturate at all-ones.

Reset
REQ-025 While RST=1 at a rising edge: out_valid=0, all control outputs 0, and rs1/rs2/rd/imm/pc_out/stall_cnt=0.
REQ-026 in_ready SHALL be 0 during any cycle with RST=1; RST SHALL take priority over flush and over the handshake.

Verification
REQ-027 Reset, then in_valid=1, ir=0x00A30333 (add x6,x6,x10), out_ready=1 -> next cycle: out_valid=1, alu_fun=0000, rf_wr_sel=3, rf_we=1, rd=6.
REQ-028 lw x5,0(x1) then add x7,x5,x2 back-to-back -> in_ready=0 for exactly one cycle, one bubble (out_valid=0), add issued next, stall_cnt=1.
REQ-029 out_ready=0 with a staged instruction for 3 cycles -> all outputs held, in_ready=0; release -> next instruction loads.
REQ-030 flush=1 while staged and in_valid=1 -> next cycle out_valid=0, and the incoming instruction is not accepted.
REQ-031 ir=0x02B50533 (mul) -> with EN_MEXT=0: illegal=1, rf_we=0; with EN_MEXT=1: mext=1, mext_fun=000, rf_we=1.
REQ-032 ir=0xFFFFF0B7 (lui x1) with XLEN=64 -> imm=0xFFFFFFFFFFFFF000, alu_fun=1001, srcA=1.

Source files
------------

// File: rtl/cu_dcdr_pipe.sv
// RV32I (+optional RV32M) decode stage with one output register, load-use
// interlock against the staged instruction, and a saturating stall counter.
module cu_dcdr_pipe #(
  parameter int XLEN    = 32,
  parameter int EN_MEXT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_fun,
  output logic             alu_srcA,
  output logic [1:0]       alu_srcB,
  output logic [1:0]       rf_wr_sel,
  output logic             rf_we,
  output logic             mem_we,
  output logic             mem_rd,
  output logic             is_branch,
  output logic             is_jal,
  output logic             is_jalr,
  output logic [2:0]       br_fun,
  output logic             mext,
  output logic [2:0]       mext_fun,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc_out,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  logic [3:0]      d_alu;
  logic            d_srca;
  logic [1:0]      d_srcb, d_wsel;
  logic            d_we, d_mwe, d_mrd, d_br, d_jal, d_jalr, d_mx, d_ill;
  logic [2:0]      d_bf, d_mf;
  logic [31:0]     imm32;
  logic [XLEN-1:0] d_imm;

  // Control fields are only set on the legal path, so an illegal decode
  // leaves every write/enable at zero.
  always_comb begin
    d_alu  = 4'd0;
    d_srca = 1'b0;
    d_srcb = 2'd0;
    d_wsel = 2'd0;
    d_we   = 1'b0;
    d_mwe  = 1'b0;
    d_mrd  = 1'b0;
    d_br   = 1'b0;
    d_jal  = 1'b0;
    d_jalr = 1'b0;
    d_mx   = 1'b0;
    d_ill  = 1'b0;
    d_bf   = 3'd0;
    d_mf   = 3'd0;
    imm32  = 32'd0;
    case (opc)
      OP_R: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          d_alu  = {f7[5], f3};
          d_wsel = 2'd3;
          d_we   = 1'b1;
        end else if (f7 == 7'h01 && EN_MEXT != 0) begin
          d_mx   = 1'b1;
          d_mf   = f3;
          d_wsel = 2'd3;
          d_we   = 1'b1;
        end else begin
          d_ill  = 1'b1;
        end
      end
      OP_IMM: begin
        imm32 = {{20{ir[31]}}, ir[31:20]};
        if ((f3 == 3'b001 || f3 == 3'b101) && !(f7 == 7'h00 || f7 == 7'h20)) begin
          d_ill = 1'b1;
        end else begin
          d_alu  = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
          d_srcb = 2'd1;
          d_wsel = 2'd3;
          d_we   = 1'b1;
        end
      end
      OP_LOAD: begin
        imm32  = {{20{ir[31]}}, ir[31:20]};
        d_srcb = 2'd1;
        d_wsel = 2'd2;
        d_we   = 1'b1;
        d_mrd  = 1'b1;
      end
      OP_STORE: begin
        imm32  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        d_srcb = 2'd2;
        d_mwe  = 1'b1;
      end
      OP_BRANCH: begin
        imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        if (f3 == 3'b010 || f3 == 3'b011) begin
          d_ill = 1'b1;
        end else begin
          d_br = 1'b1;
          d_bf = f3;
        end
      end
      OP_LUI: begin
        imm32  = {ir[31:12], 12'd0};
        d_alu  = 4'b1001;
        d_srca = 1'b1;
        d_wsel = 2'd3;
        d_we   = 1'b1;
      end
      OP_AUIPC: begin
        imm32  = {ir[31:12], 12'd0};
        d_srca = 1'b1;
        d_srcb = 2'd3;
        d_wsel = 2'd3;
        d_we   = 1'b1;
      end
      OP_JAL: begin
        imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        d_jal = 1'b1;
        d_we  = 1'b1;
      end
      OP_JALR: begin
        imm32  = {{20{ir[31]}}, ir[31:20]};
        d_jalr = 1'b1;
        d_we   = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (ir[11:7] == 5'd0) d_we = 1'b0;
  end

  generate
    if (XLEN > 32) begin : g_sext
      assign d_imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_nosext
      assign d_imm = imm32;
    end
  endgenerate

  // Handshake: an instruction moves in on a cycle with in_valid & in_ready;
  // the staged word leaves on out_valid & out_ready. in_ready is purely
  // combinational and drops on reset, flush, a blocked output or load-use.
  logic uses_rs1, uses_rs2, hz, adv, take;
  assign uses_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  assign uses_rs2 = (opc == OP_R) || (opc == OP_STORE) || (opc == OP_BRANCH);
  assign hz = out_valid && mem_rd && (rd != 5'd0) &&
              ((uses_rs1 && ir[19:15] == rd) || (uses_rs2 && ir[24:20] == rd));
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & ~hz & ~flush & ~RST;
  assign take     = in_valid & in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      alu_fun   <= 4'd0;
      alu_srcA  <= 1'b0;
      alu_srcB  <= 2'd0;
      rf_wr_sel <= 2'd0;
      rf_we     <= 1'b0;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
      is_branch <= 1'b0;
      is_jal    <= 1'b0;
      is_jalr   <= 1'b0;
      br_fun    <= 3'd0;
      mext      <= 1'b0;
      mext_fun  <= 3'd0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rd        <= 5'd0;
      imm       <= '0;
      pc_out    <= '0;
      illegal   <= 1'b0;
    end else if (flush || (adv && !take)) begin
      out_valid <= 1'b0;
      rf_we     <= 1'b0;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
      is_branch <= 1'b0;
      is_jal    <= 1'b0;
      is_jalr   <= 1'b0;
      mext      <= 1'b0;
      illegal   <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
      alu_fun   <= d_alu;
      alu_srcA  <= d_srca;
      alu_srcB  <= d_srcb;
      rf_wr_sel <= d_wsel;
      rf_we     <= d_we;
      mem_we    <= d_mwe;
      mem_rd    <= d_mrd;
      is_branch <= d_br;
      is_jal    <= d_jal;
      is_jalr   <= d_jalr;
      br_fun    <= d_bf;
      mext      <= d_mx;
      mext_fun  <= d_mf;
      rs1       <= ir[19:15];
      rs2       <= ir[24:20];
      rd        <= ir[11:7];
      imm       <= d_imm;
      pc_out    <= pc_in;
      illegal   <= d_ill;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (in_valid && hz && adv && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cu_dcdr_pipe.sv
// Bench for cu_dcdr_pipe: a 64-bit/M-enabled instance and a 32-bit/no-M
// instance with a 3-bit stall counter, both driven from the same inputs.
module tb_cu_dcdr_pipe;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, in_valid, flush, out_ready;
  logic [31:0] ir;
  logic [63:0] pc_in;

  logic        in_ready, out_valid, alu_srcA, rf_we, mem_we, mem_rd;
  logic        is_branch, is_jal, is_jalr, mext, illegal;
  logic [3:0]  alu_fun;
  logic [1:0]  alu_srcB, rf_wr_sel;
  logic [2:0]  br_fun, mext_fun;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] imm, pc_out;
  logic [15:0] stall_cnt;

  logic        b_in_ready, b_out_valid, b_alu_srcA, b_rf_we, b_mem_we, b_mem_rd;
  logic        b_is_branch, b_is_jal, b_is_jalr, b_mext, b_illegal;
  logic [3:0]  b_alu_fun;
  logic [1:0]  b_alu_srcB, b_rf_wr_sel;
  logic [2:0]  b_br_fun, b_mext_fun;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [31:0] b_imm, b_pc_out;
  logic [2:0]  b_stall_cnt;

  cu_dcdr_pipe #(.XLEN(64), .EN_MEXT(1), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
    .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_fun(alu_fun), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .rf_wr_sel(rf_wr_sel), .rf_we(rf_we), .mem_we(mem_we), .mem_rd(mem_rd),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .br_fun(br_fun),
    .mext(mext), .mext_fun(mext_fun), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .pc_out(pc_out), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  cu_dcdr_pipe #(.XLEN(32), .EN_MEXT(0), .CNT_W(3)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(b_in_ready), .ir(ir),
    .pc_in(pc_in[31:0]), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .alu_fun(b_alu_fun), .alu_srcA(b_alu_srcA), .alu_srcB(b_alu_srcB),
    .rf_wr_sel(b_rf_wr_sel), .rf_we(b_rf_we), .mem_we(b_mem_we), .mem_rd(b_mem_rd),
    .is_branch(b_is_branch), .is_jal(b_is_jal), .is_jalr(b_is_jalr), .br_fun(b_br_fun),
    .mext(b_mext), .mext_fun(b_mext_fun), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .imm(b_imm),
    .pc_out(b_pc_out), .illegal(b_illegal), .stall_cnt(b_stall_cnt)
  );

  typedef struct packed {
    logic [3:0]  alu;
    logic        a;
    logic [1:0]  b;
    logic [1:0]  ws;
    logic        we, mwe, mrd, br, jal, jalr;
    logic [2:0]  bf;
    logic        mx;
    logic [2:0]  mf;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  alu;
    logic        a;
    logic [1:0]  b;
    logic [1:0]  ws;
    logic [6:0]  en;   // {we, mwe, mrd, br, jal, jalr, mx}
    logic        ill;
    logic [63:0] imm;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // reference state: what the staged word should be after each edge
  logic        m_valid = 1'b0;
  dec_t        m_d = '0;
  dec_t        m_d0 = '0;
  logic [63:0] m_pc = '0;
  int          m_stall = 0;
  int          m_stall0 = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic dec_t decode(input logic [31:0] i, input bit m_en);
    dec_t d;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    d = '0;
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.rd  = i[11:7];
    if (op == 7'b0110011) begin
      if (f7 == 7'h00 || f7 == 7'h20) begin d.alu = {f7[5], f3}; d.ws = 3; d.we = 1; end
      else if (f7 == 7'h01 && m_en) begin d.mx = 1; d.mf = f3; d.ws = 3; d.we = 1; end
      else d.ill = 1;
    end else if (op == 7'b0010011) begin
      d.imm = {{52{i[31]}}, i[31:20]};
      if (f3 inside {3'b001, 3'b101} && !(f7 inside {7'h00, 7'h20})) d.ill = 1;
      else begin
        d.alu = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
        d.b = 1; d.ws = 3; d.we = 1;
      end
    end else if (op == 7'b0000011) begin
      d.imm = {{52{i[31]}}, i[31:20]};
      d.b = 1; d.ws = 2; d.we = 1; d.mrd = 1;
    end else if (op == 7'b0100011) begin
      d.imm = {{52{i[31]}}, i[31:25], i[11:7]};
      d.b = 2; d.mwe = 1;
    end else if (op == 7'b1100011) begin
      d.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      if (f3 == 3'b010 || f3 == 3'b011) d.ill = 1;
      else begin d.br = 1; d.bf = f3; end
    end else if (op == 7'b0110111) begin
      d.imm = {{32{i[31]}}, i[31:12], 12'h000};
      d.alu = 4'b1001; d.a = 1; d.ws = 3; d.we = 1;
    end else if (op == 7'b0010111) begin
      d.imm = {{32{i[31]}}, i[31:12], 12'h000};
      d.a = 1; d.b = 3; d.ws = 3; d.we = 1;
    end else if (op == 7'b1101111) begin
      d.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      d.jal = 1; d.we = 1;
    end else if (op == 7'b1100111) begin
      d.imm = {{52{i[31]}}, i[31:20]};
      d.jalr = 1; d.we = 1;
    end else begin
      d.ill = 1;
    end
    if (d.rd == 5'd0) d.we = 0;
    return d;
  endfunction

  function automatic dec_t quiet(input dec_t d);
    dec_t q;
    q = d;
    q.we = 0; q.mwe = 0; q.mrd = 0; q.br = 0; q.jal = 0; q.jalr = 0; q.mx = 0;
    return q;
  endfunction

  // load-use: a staged load whose destination the incoming word reads
  function automatic logic model_hz(input logic [31:0] i);
    logic [6:0] op;
    logic r1, r2;
    op = i[6:0];
    if (!(m_valid && m_d.mrd && m_d.rd != 5'd0)) return 1'b0;
    r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return (r1 && i[19:15] == m_d.rd) || (r2 && i[24:20] == m_d.rd);
  endfunction

  task automatic check_outputs();
    dec_t a, a0, e0;
    a.alu = alu_fun; a.a = alu_srcA; a.b = alu_srcB; a.ws = rf_wr_sel;
    a.we = rf_we; a.mwe = mem_we; a.mrd = mem_rd; a.br = is_branch;
    a.jal = is_jal; a.jalr = is_jalr; a.bf = br_fun; a.mx = mext; a.mf = mext_fun;
    a.rs1 = rs1; a.rs2 = rs2; a.rd = rd; a.imm = imm; a.ill = illegal;
    a0.alu = b_alu_fun; a0.a = b_alu_srcA; a0.b = b_alu_srcB; a0.ws = b_rf_wr_sel;
    a0.we = b_rf_we; a0.mwe = b_mem_we; a0.mrd = b_mem_rd; a0.br = b_is_branch;
    a0.jal = b_is_jal; a0.jalr = b_is_jalr; a0.bf = b_br_fun; a0.mx = b_mext; a0.mf = b_mext_fun;
    a0.rs1 = b_rs1; a0.rs2 = b_rs2; a0.rd = b_rd; a0.imm = {32'h0, b_imm}; a0.ill = b_illegal;
    e0 = m_d0;
    e0.imm = {32'h0, m_d0.imm[31:0]};
    chk("out_valid", 128'(out_valid), 128'(m_valid));
    chk("out_valid_32", 128'(b_out_valid), 128'(m_valid));
    if (m_valid) begin
      chk("word", 128'(a), 128'(m_d));
      chk("word_32", 128'(a0), 128'(e0));
      chk("pc_out", 128'(pc_out), 128'(m_pc));
      chk("pc_out_32", 128'(b_pc_out), 128'(m_pc[31:0]));
    end else begin
      chk("bubble_en", 128'({a.we, a.mwe, a.mrd, a.br, a.jal, a.jalr, a.mx}),
          128'({m_d.we, m_d.mwe, m_d.mrd, m_d.br, m_d.jal, m_d.jalr, m_d.mx}));
      chk("bubble_en_32", 128'({a0.we, a0.mwe, a0.mrd, a0.br, a0.jal, a0.jalr, a0.mx}),
          128'({m_d0.we, m_d0.mwe, m_d0.mrd, m_d0.br, m_d0.jal, m_d0.jalr, m_d0.mx}));
    end
    chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    chk("stall_cnt_32", 128'(b_stall_cnt), 128'(m_stall0));
  endtask

  // one clock: drive at negedge, check in_ready, step the model, check outputs
  task automatic cycle(input logic rst, input logic iv, input logic [31:0] i,
                       input logic fl, input logic ordy);
    logic adv, hz, rdy;
    logic [63:0] pcv;
    pcv = {$urandom, $urandom};
    RST = rst; in_valid = iv; ir = i; flush = fl; out_ready = ordy; pc_in = pcv;
    #1;
    adv = ordy | !m_valid;
    hz  = model_hz(i);
    rdy = adv & !hz & !fl & !rst;
    chk("in_ready", 128'(in_ready), 128'(rdy));
    chk("in_ready_32", 128'(b_in_ready), 128'(rdy));
    @(posedge CLK);
    if (rst) begin
      m_valid = 0; m_d = '0; m_d0 = '0; m_pc = '0; m_stall = 0; m_stall0 = 0;
    end else begin
      if (iv && hz && adv) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall0 < 7) m_stall0++;
      end
      if (fl) begin
        m_valid = 0; m_d = quiet(m_d); m_d0 = quiet(m_d0);
      end else if (adv) begin
        if (iv && rdy) begin
          m_valid = 1; m_d = decode(i, 1'b1); m_d0 = decode(i, 1'b0); m_pc = pcv;
        end else begin
          m_valid = 0; m_d = quiet(m_d); m_d0 = quiet(m_d0);
        end
      end
    end
    @(negedge CLK);
    check_outputs();
  endtask

  function automatic logic [31:0] gen_ir();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 9))
      0: begin
        i[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
          0: i[31:25] = 7'h00;
          1: i[31:25] = 7'h20;
          2: i[31:25] = 7'h01;
          default: ;
        endcase
      end
      1: begin
        i[6:0] = 7'b0010011;
        if ($urandom_range(0, 2) != 0) i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      2: i[6:0] = 7'b0000011;
      3: i[6:0] = 7'b0100011;
      4: i[6:0] = 7'b1100011;
      5: i[6:0] = 7'b0110111;
      6: i[6:0] = 7'b0010111;
      7: i[6:0] = 7'b1101111;
      8: i[6:0] = 7'b1100111;
      default: ;
    endcase
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  localparam logic [31:0] LW_X5  = 32'h0000A283;  // lw  x5,0(x1)
  localparam logic [31:0] ADD_X7 = 32'h002283B3;  // add x7,x5,x2
  localparam logic [31:0] ADD_X6 = 32'h00A30333;  // add x6,x6,x10
  localparam logic [31:0] SUB_XA = 32'h40B50533;  // sub x10,x10,x11
  localparam logic [31:0] MUL_XA = 32'h02B50533;  // mul x10,x10,x11

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{32'h00A30333, 4'h0, 1'b0, 2'd0, 2'd3, 7'b1000000, 1'b0, 64'h0};
    tbl[1]  = '{32'h02B50533, 4'h0, 1'b0, 2'd0, 2'd3, 7'b1000001, 1'b0, 64'h0};
    tbl[2]  = '{32'hFFFFF0B7, 4'h9, 1'b1, 2'd0, 2'd3, 7'b1000000, 1'b0, 64'hFFFFFFFFFFFFF000};
    tbl[3]  = '{32'h40B50533, 4'h8, 1'b0, 2'd0, 2'd3, 7'b1000000, 1'b0, 64'h0};
    tbl[4]  = '{32'hFFF00093, 4'h0, 1'b0, 2'd1, 2'd3, 7'b1000000, 1'b0, 64'hFFFFFFFFFFFFFFFF};
    tbl[5]  = '{32'h4032D293, 4'hD, 1'b0, 2'd1, 2'd3, 7'b1000000, 1'b0, 64'h403};
    tbl[6]  = '{32'h02029293, 4'h0, 1'b0, 2'd0, 2'd0, 7'b0000000, 1'b1, 64'h20};
    tbl[7]  = '{32'h0000A283, 4'h0, 1'b0, 2'd1, 2'd2, 7'b1010000, 1'b0, 64'h0};
    tbl[8]  = '{32'h00512423, 4'h0, 1'b0, 2'd2, 2'd0, 7'b0100000, 1'b0, 64'h8};
    tbl[9]  = '{32'hFE208EE3, 4'h0, 1'b0, 2'd0, 2'd0, 7'b0001000, 1'b0, 64'hFFFFFFFFFFFFFFFC};
    tbl[10] = '{32'hFE20AEE3, 4'h0, 1'b0, 2'd0, 2'd0, 7'b0000000, 1'b1, 64'hFFFFFFFFFFFFFFFC};
    tbl[11] = '{32'h008000EF, 4'h0, 1'b0, 2'd0, 2'd0, 7'b1000100, 1'b0, 64'h8};
    tbl[12] = '{32'h00008067, 4'h0, 1'b0, 2'd0, 2'd0, 7'b0000010, 1'b0, 64'h0};
    tbl[13] = '{32'h80000197, 4'h0, 1'b1, 2'd3, 2'd3, 7'b1000000, 1'b0, 64'hFFFFFFFF80000000};
    tbl[14] = '{32'h0000007F, 4'h0, 1'b0, 2'd0, 2'd0, 7'b0000000, 1'b1, 64'h0};
    tbl[15] = '{32'h00208033, 4'h0, 1'b0, 2'd0, 2'd3, 7'b0000000, 1'b0, 64'h0};
    tbl[16] = '{32'h04208133, 4'h0, 1'b0, 2'd0, 2'd0, 7'b0000000, 1'b1, 64'h0};

    RST = 1'b1; in_valid = 1'b0; ir = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge CLK);

    // reset, with a request pending and the output side open
    cycle(1, 1, ADD_X6, 0, 1);
    cycle(1, 1, ADD_X6, 1, 1);
    chk("reset_state", 128'({out_valid, alu_fun, alu_srcA, alu_srcB, rf_wr_sel, rf_we, mem_we,
                             mem_rd, is_branch, is_jal, is_jalr, mext, illegal, rs1, rs2, rd,
                             imm, pc_out, stall_cnt}), 128'(0));

    // first instruction after reset
    cycle(0, 1, ADD_X6, 0, 1);
    chk("add_first", 128'({out_valid, alu_fun, rf_wr_sel, rf_we, rd}),
        128'({1'b1, 4'h0, 2'd3, 1'b1, 5'd6}));

    // decode table
    for (int k = 0; k < 17; k++) begin
      cycle(0, 1, tbl[k].ir, 0, 1);
      chk($sformatf("tbl%0d_ctl", k),
          128'({out_valid, alu_fun, alu_srcA, alu_srcB, rf_wr_sel,
                rf_we, mem_we, mem_rd, is_branch, is_jal, is_jalr, mext, illegal}),
          128'({1'b1, tbl[k].alu, tbl[k].a, tbl[k].b, tbl[k].ws, tbl[k].en, tbl[k].ill}));
      chk($sformatf("tbl%0d_imm", k), 128'(imm), 128'(tbl[k].imm));
      cycle(0, 0, 32'h0, 0, 1);
    end

    // M extension present vs absent
    cycle(0, 1, MUL_XA, 0, 1);
    chk("mul_m1", 128'({mext, mext_fun, rf_we, illegal}), 128'({1'b1, 3'b000, 1'b1, 1'b0}));
    chk("mul_m0", 128'({b_illegal, b_rf_we, b_mext, b_out_valid}), 128'({1'b1, 1'b0, 1'b0, 1'b1}));

    // load-use interlock
    cycle(1, 0, 32'h0, 0, 1);
    cycle(0, 1, LW_X5, 0, 1);
    cycle(0, 1, ADD_X7, 0, 1);
    chk("ldu_bubble", 128'({out_valid, stall_cnt}), 128'({1'b0, 16'd1}));
    cycle(0, 1, ADD_X7, 0, 1);
    chk("ldu_issue", 128'({out_valid, rd, stall_cnt}), 128'({1'b1, 5'd7, 16'd1}));

    // output back-pressure for three cycles, then release
    cycle(0, 1, ADD_X6, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, SUB_XA, 0, 0);
      chk("hold_word", 128'({out_valid, rd, alu_fun, in_ready}), 128'({1'b1, 5'd6, 4'h0, 1'b0}));
    end
    cycle(0, 1, SUB_XA, 0, 1);
    chk("release", 128'({out_valid, rd, alu_fun}), 128'({1'b1, 5'd10, 4'h8}));

    // flush with a staged word and a stalled output side
    cycle(0, 1, ADD_X6, 1, 0);
    chk("flush_kill", 128'({out_valid, b_out_valid}), 128'(0));
    cycle(0, 0, 32'h0, 0, 1);
    chk("flush_noaccept", 128'({out_valid, rf_we}), 128'(0));

    // stall counter saturation on the 3-bit instance
    for (int k = 0; k < 9; k++) begin
      cycle(0, 1, LW_X5, 0, 1);
      cycle(0, 1, ADD_X7, 0, 1);
      cycle(0, 1, ADD_X7, 0, 1);
    end
    chk("stall_sat_32", 128'(b_stall_cnt), 128'(3'd7));

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), gen_ir(),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
